// File: rtl/genius_seq_engine.sv
// genius_seq_engine
//   Sequence-memory ("Genius") game engine. An LFSR that runs every cycle
//   fills a sequence memory at game start; the engine then shows a growing
//   prefix of that sequence and checks the player's replay, one button press
//   per symbol, until the full sequence is replayed (win) or the player errs
//   or idles too long (lose).
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-low
//   start       in   level, only looked at in IDLE
//   btn         in   [N_BTN] synchronised button levels
//   state       out  [3] FSM state code (IDLE 0, FILL 1, SHOW 2, INPUT 3, ADVANCE 4)
//   level       out  [LW] current sequence length
//   step        out  [LW] index within the sequence being shown or expected
//   show_valid  out  high while a symbol is on display
//   show_sym    out  [SW] symbol on display, 0 when show_valid is low
//   busy        out  high in every state except IDLE
//   win, lose   out  one-cycle pulses in the first IDLE cycle after a game
module genius_seq_engine #(
  parameter int          N_BTN         = 4,
  parameter int          MAX_LEVEL     = 16,
  parameter int          SHOW_TICKS    = 4,
  parameter int          TIMEOUT_TICKS = 64,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         SW            = ($clog2(N_BTN) > 1) ? $clog2(N_BTN) : 1,
  localparam int         LW            = $clog2(MAX_LEVEL + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N_BTN-1:0] btn,
  output logic [2:0]       state,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    step,
  output logic             show_valid,
  output logic [SW-1:0]    show_sym,
  output logic             busy,
  output logic             win,
  output logic             lose
);

  localparam int AW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int CW = $clog2(SHOW_TICKS + 1);
  localparam int TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_SHOW    = 3'd2,
    ST_INPUT   = 3'd3,
    ST_ADVANCE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    level_q, level_d;
  logic [LW-1:0]    step_q, step_d;
  logic [CW-1:0]    tick_q, tick_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [N_BTN-1:0] btn_q;

  logic [SW-1:0]    seq_mem [MAX_LEVEL];
  logic             mem_we;

  logic [7:0]       sym_wide;
  logic [SW-1:0]    gen_sym;
  logic [SW-1:0]    exp_sym;
  logic [N_BTN-1:0] press;
  logic             press_onehot;
  logic [SW-1:0]    press_idx;
  logic             last_step;

  // Galois LFSR, free-running in every state so the sequence depends on
  // how long the player waited before pressing start.
  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    sym_wide = lfsr_q[7:0] % 8'(N_BTN);
    gen_sym  = sym_wide[SW-1:0];
  end

  assign exp_sym   = seq_mem[step_q[AW-1:0]];
  assign last_step = (step_q == level_q - LW'(1));

  // Rising-edge detect. btn_q follows btn every cycle, so a held button
  // produces exactly one press.
  always_comb begin
    press        = btn & ~btn_q;
    press_onehot = (press != '0) && ((press & (press - N_BTN'(1))) == '0);
    press_idx    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (press[i]) press_idx = SW'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      step_q  <= '0;
      tick_q  <= '0;
      tmo_q   <= '0;
      waddr_q <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      lfsr_q  <= SEED;
      btn_q   <= '1;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      tmo_q   <= tmo_d;
      waddr_q <= waddr_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      lfsr_q  <= lfsr_d;
      btn_q   <= btn;
    end
  end

  // Sequence storage has no reset; it is always rewritten by FILL before use.
  always_ff @(posedge clock) begin
    if (mem_we) seq_mem[waddr_q] <= gen_sym;
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    step_d  = step_q;
    tick_d  = tick_q;
    tmo_d   = tmo_q;
    waddr_d = waddr_q;
    win_d   = 1'b0;
    lose_d  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          waddr_d = '0;
        end
      end
      ST_FILL: begin
        mem_we = reset;
        if (waddr_q == AW'(MAX_LEVEL - 1)) begin
          state_d = ST_SHOW;
          level_d = LW'(1);
          step_d  = '0;
          tick_d  = '0;
        end else begin
          waddr_d = waddr_q + AW'(1);
        end
      end
      ST_SHOW: begin
        // SHOW_TICKS display cycles followed by one blank cycle per step.
        if (tick_q == CW'(SHOW_TICKS)) begin
          tick_d = '0;
          if (last_step) begin
            state_d = ST_INPUT;
            step_d  = '0;
            tmo_d   = '0;
          end else begin
            step_d = step_q + LW'(1);
          end
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      ST_INPUT: begin
        if (press == '0) begin
          if (TIMEOUT_TICKS != 0) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_d == TW'(TIMEOUT_TICKS)) begin
              lose_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end else if (press_onehot && (press_idx == exp_sym)) begin
          tmo_d = '0;
          if (last_step) state_d = ST_ADVANCE;
          else           step_d  = step_q + LW'(1);
        end else begin
          // Wrong symbol or several buttons rising together.
          lose_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ADVANCE: begin
        if (level_q == LW'(MAX_LEVEL)) begin
          win_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          level_d = level_q + LW'(1);
          step_d  = '0;
          tick_d  = '0;
          state_d = ST_SHOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state      = state_q;
  assign level      = level_q;
  assign step       = step_q;
  assign show_valid = (state_q == ST_SHOW) && (tick_q < CW'(SHOW_TICKS));
  assign show_sym   = show_valid ? exp_sym : '0;
  assign busy       = (state_q != ST_IDLE);
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_genius_seq_engine.sv
// Bench for genius_seq_engine: a game-level model predicts every output each
// cycle; directed scenarios drive the game and pin key values by hand.
module tb_genius_seq_engine;
  localparam int          N_BTN         = 4;
  localparam int          MAX_LEVEL     = 4;
  localparam int          SHOW_TICKS    = 2;
  localparam int          TIMEOUT_TICKS = 8;
  localparam logic [15:0] SEED          = 16'hACE1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn   = 4'hF;
  logic [2:0] state;
  logic [2:0] level, step;
  logic       show_valid;
  logic [1:0] show_sym;
  logic       busy, win, lose;

  logic       reset_z = 1'b0;
  logic       start_z = 1'b0;
  logic [3:0] btn_z   = 4'h0;
  logic [2:0] state_z;
  logic [2:0] level_z, step_z;
  logic       show_valid_z;
  logic [1:0] show_sym_z;
  logic       busy_z, win_z, lose_z;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  genius_seq_engine #(
    .N_BTN(N_BTN), .MAX_LEVEL(MAX_LEVEL), .SHOW_TICKS(SHOW_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS), .SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .btn(btn),
    .state(state), .level(level), .step(step), .show_valid(show_valid),
    .show_sym(show_sym), .busy(busy), .win(win), .lose(lose)
  );

  genius_seq_engine #(
    .N_BTN(N_BTN), .MAX_LEVEL(MAX_LEVEL), .SHOW_TICKS(SHOW_TICKS),
    .TIMEOUT_TICKS(0), .SEED(SEED)
  ) dut_z (
    .clock(clock), .reset(reset_z), .start(start_z), .btn(btn_z),
    .state(state_z), .level(level_z), .step(step_z), .show_valid(show_valid_z),
    .show_sym(show_sym_z), .busy(busy_z), .win(win_z), .lose(lose_z)
  );

  // ---------------- game model ----------------
  bit          m_ok = 1'b0;
  int          m_phase, m_level, m_step, m_k, m_idle, m_fill;
  logic [15:0] m_lfsr;
  logic [3:0]  m_btn_prev;
  int          m_seq [4];
  bit          m_win, m_lose;

  task automatic model_step();
    logic [3:0] press, want;
    if (!reset) begin
      m_ok = 1'b1; m_lfsr = SEED; m_phase = 0; m_level = 0; m_step = 0;
      m_k = 0; m_idle = 0; m_fill = 0; m_btn_prev = 4'hF; m_win = 0; m_lose = 0;
    end else begin
      press  = btn & ~m_btn_prev;
      m_win  = 0;
      m_lose = 0;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_fill = 0; end
        1: begin
          m_seq[m_fill] = int'(m_lfsr[7:0]) % N_BTN;
          m_fill++;
          if (m_fill == MAX_LEVEL) begin m_phase = 2; m_level = 1; m_step = 0; m_k = 0; end
        end
        2: begin
          m_k++;
          if (m_k == m_level * (SHOW_TICKS + 1)) begin m_phase = 3; m_step = 0; m_idle = 0; end
        end
        3: begin
          want = 4'b0001 << m_seq[m_step];
          if (press == 4'h0) begin
            if (TIMEOUT_TICKS != 0) begin
              m_idle++;
              if (m_idle == TIMEOUT_TICKS) begin m_lose = 1; m_phase = 0; end
            end
          end else if (press == want) begin
            m_idle = 0;
            if (m_step == m_level - 1) m_phase = 4;
            else m_step++;
          end else begin
            m_lose = 1; m_phase = 0;
          end
        end
        4: begin
          if (m_level == MAX_LEVEL) begin m_win = 1; m_phase = 0; end
          else begin m_level++; m_k = 0; m_phase = 2; end
        end
        default: ;
      endcase
      m_btn_prev = btn;
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    int  e_step;
    bit  e_valid;
    int  e_sym;
    @(negedge clock);
    if (m_ok) begin
      e_step  = (m_phase == 2) ? m_k / (SHOW_TICKS + 1) : m_step;
      e_valid = (m_phase == 2) && ((m_k % (SHOW_TICKS + 1)) < SHOW_TICKS);
      e_sym   = e_valid ? m_seq[e_step] : 0;
      chk("state",      16'(state),      16'(m_phase));
      chk("level",      16'(level),      16'(m_level));
      chk("step",       16'(step),       16'(e_step));
      chk("show_valid", 16'(show_valid), 16'(e_valid));
      chk("show_sym",   16'(show_sym),   16'(e_sym));
      chk("busy",       16'(busy),       16'(m_phase != 0));
      chk("win",        16'(win),        16'(m_win));
      chk("lose",       16'(lose),       16'(m_lose));
    end
  end

  // Shown-symbol recorder for the reproducibility scenario.
  int         rec_sel = 0;
  logic [1:0] rec_a[$];
  logic [1:0] rec_b[$];
  initial forever begin
    @(posedge clock);
    #2;
    if (show_valid === 1'b1) begin
      if (rec_sel == 1) rec_a.push_back(show_sym);
      if (rec_sel == 2) rec_b.push_back(show_sym);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (state !== s) begin
      checks++;
      failures++;
      $display("FAIL wait_state actual=%0d required=%0d time=%0t", state, s, $time);
    end
  endtask

  task automatic press_sym(input int s);
    btn = 4'(1 << s);
    @(negedge clock);
    btn = 4'h0;
    @(negedge clock);
  endtask

  task automatic play_level(input int lvl);
    wait_state(3'd3, 200);
    for (int i = 0; i < lvl; i++) press_sym(m_seq[i]);
  endtask

  task automatic start_game(input int gap);
    cyc(gap);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog time=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, wrong;
    int n;
    // Reset with all buttons held.
    cyc(3);
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_level", 16'(level), 16'd0);
    chk("rst_step",  16'(step),  16'd0);
    chk("rst_valid", 16'(show_valid), 16'd0);
    chk("rst_sym",   16'(show_sym), 16'd0);
    chk("rst_busy",  16'(busy), 16'd0);
    chk("rst_win",   16'(win),  16'd0);
    chk("rst_lose",  16'(lose), 16'd0);
    reset = 1'b1;

    // Game 1: three idle cycles before start gives sequence 2,3,3,1.
    cyc(3);
    btn   = 4'h0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_state", 16'(state), 16'd1);
      chk("fill_busy",  16'(busy),  16'd1);
      cyc(1);
    end
    chk("seq0_model", 16'(m_seq[0]), 16'd2);
    chk("seq1_model", 16'(m_seq[1]), 16'd3);
    chk("seq2_model", 16'(m_seq[2]), 16'd3);
    chk("seq3_model", 16'(m_seq[3]), 16'd1);
    chk("show_state", 16'(state), 16'd2);
    chk("show_lvl1",  16'(level), 16'd1);
    chk("show_v0",    16'(show_valid), 16'd1);
    chk("show_sym0",  16'(show_sym), 16'd2);
    cyc(1);
    chk("show_v1", 16'(show_valid), 16'd1);
    cyc(1);
    chk("show_v2", 16'(show_valid), 16'd0);
    for (int l = 1; l <= MAX_LEVEL; l++) play_level(l);
    chk("win_pulse", 16'(win),   16'd1);
    chk("win_state", 16'(state), 16'd0);
    chk("win_level", 16'(level), 16'd4);
    cyc(1);
    chk("win_clear", 16'(win), 16'd0);

    // Game 2: start held through the game, wrong symbol at level 2 step 1.
    start = 1'b1;
    cyc(1);
    play_level(1);
    wait_state(3'd3, 200);
    start = 1'b0;
    press_sym(m_seq[0]);
    wrong = (m_seq[1] + 1) % 4;
    btn = 4'(1 << wrong);
    cyc(1);
    btn = 4'h0;
    chk("wrong_lose",  16'(lose),  16'd1);
    chk("wrong_state", 16'(state), 16'd0);
    chk("wrong_level", 16'(level), 16'd2);
    chk("wrong_step",  16'(step),  16'd1);
    cyc(1);
    chk("lose_clear", 16'(lose), 16'd0);

    // Game 3: two buttons rising together, one of them the expected symbol.
    start_game(0);
    wait_state(3'd3, 200);
    s = m_seq[0];
    btn = 4'((1 << s) | (1 << ((s + 1) % 4)));
    cyc(1);
    btn = 4'h0;
    chk("multi_lose",  16'(lose),  16'd1);
    chk("multi_state", 16'(state), 16'd0);

    // Game 4: timeout after 8 idle INPUT cycles.
    start_game(1);
    wait_state(3'd3, 200);
    cyc(7);
    chk("tmo_still_input", 16'(state), 16'd3);
    cyc(1);
    chk("tmo_state", 16'(state), 16'd0);
    chk("tmo_lose",  16'(lose),  16'd1);

    // Reset during SHOW, then replay with the same reset-to-start gap.
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(3);
    rec_sel = 1;
    start_game(0);
    play_level(1);
    wait_state(3'd2, 50);
    cyc(4);
    reset = 1'b0;
    cyc(1);
    rec_sel = 0;
    chk("midrst_state", 16'(state), 16'd0);
    chk("midrst_busy",  16'(busy),  16'd0);
    chk("midrst_level", 16'(level), 16'd0);
    chk("midrst_valid", 16'(show_valid), 16'd0);
    chk("midrst_lose",  16'(lose), 16'd0);
    cyc(1);
    reset = 1'b1;
    cyc(3);
    rec_sel = 2;
    start_game(0);
    play_level(1);
    wait_state(3'd2, 50);
    cyc(4);
    rec_sel = 0;
    chk("repro_len_a", 16'(rec_a.size()), 16'd6);
    chk("repro_len_b", 16'(rec_b.size()), 16'(rec_a.size()));
    n = (rec_a.size() < rec_b.size()) ? rec_a.size() : rec_b.size();
    for (int i = 0; i < n; i++) chk("repro_sym", 16'(rec_b[i]), 16'(rec_a[i]));
    if (rec_a.size() > 3) chk("repro_a3", 16'(rec_a[3]), 16'd2);
    if (rec_a.size() > 5) chk("repro_a5", 16'(rec_a[5]), 16'd3);

    // Timeout disabled instance: stays in INPUT indefinitely.
    reset_z = 1'b1;
    cyc(2);
    start_z = 1'b1;
    cyc(1);
    start_z = 1'b0;
    n = 0;
    while (state_z !== 3'd3 && n < 50) begin
      cyc(1);
      n++;
    end
    chk("notmo_enter", 16'(state_z), 16'd3);
    cyc(1000);
    chk("notmo_state", 16'(state_z), 16'd3);
    chk("notmo_lose",  16'(lose_z),  16'd0);
    chk("notmo_level", 16'(level_z), 16'd1);
    chk("notmo_busy",  16'(busy_z),  16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
